apb_tx_fifo_slave: RTL
======================

Name: apb_tx_fifo_slave

Overview:
- APB completer sitting directly downstream of the team's APB master, on one PSELx line.
- Accepts single-beat APB writes of ALU result bytes into a DEPTH-entry show-ahead FIFO.
- Presents the buffered bytes to a serial protocol engine over a valid/ready stream.
- Inserts APB wait states (PREADY low) while the FIFO is full; APB reads return a 1-bit status.

Parameters:
- m, 8, data width of PWDATA and o_data
- DEPTH, 4, FIFO entries; power of two, ≥2
- AW, $clog2(DEPTH), pointer width

Ports:
- PCLK  input  1  clock, all logic on rising edge
- PRESET  input  1  reset; synchronous, active-high
- PSEL  input  1  slave select from master (one of PSEL0..3)
- PENABLE  input  1  APB access-phase strobe
- PWRITE  input  1  1 = write, 0 = read
- PWDATA  input  m  write data
- PREADY  output  1  transfer completion / wait-state
- PRDATA  output  1  read status: 1 = FIFO empty (all data drained)
- o_data  output  m  head-of-FIFO byte
- o_valid  output  1  o_data valid (FIFO non-empty)
- i_ready  input  1  downstream protocol engine accepts o_data
- o_level  output  AW+1  current FIFO occupancy, 0..DEPTH
- o_proto_err  output  1  sticky APB sequencing error flag

Behaviour:
- Reset (PRESET=1 at posedge), overriding everything, including reset mid-transfer or mid-drain:
  - FSM goes to IDLE; rd/wr pointers and count cleared; FIFO contents discarded.
  - o_valid=0, o_level=0, o_proto_err=0, PREADY=0, PRDATA=0.
- FSM states, registered:
  - IDLE: PSEL=0.
    - PSEL=1 & PENABLE=0 -> SETUP.
    - PSEL=1 & PENABLE=1 -> set o_proto_err, go to COMPLETE; no push.
  - SETUP: → ACCESS next cycle if PSEL=1 & PENABLE=1; → IDLE if PSEL=0; stays in SETUP if PSEL=1 & PENABLE=0.
  - ACCESS: PREADY is combinational in this state.
    - Write: PREADY = ~full (full = registered count==DEPTH).
    - Read: PREADY = 1 unconditionally.
    - PREADY=1 -> transfer completes this cycle; go to COMPLETE.
    - PREADY=0 -> stay in ACCESS (wait state).
    - PSEL drops while in ACCESS -> IDLE, set o_proto_err, no push.
  - COMPLETE: PREADY=0, no push. → IDLE when PSEL=0; → SETUP when PSEL=1 & PENABLE=0 (back-to-back). This guarantees exactly one push per transfer even if the master holds PENABLE high extra cycles.
- PREADY is 0 in IDLE, SETUP and COMPLETE.
- Push: in ACCESS with PSEL & PENABLE & PWRITE & PREADY, write PWDATA into mem[wr_ptr]; wr_ptr increments and wraps DEPTH-1 → 0.
- Read data: PRDATA = (count==0) during ACCESS with PWRITE=0; 0 in all other states. Reads never alter the FIFO.
- Pop: o_valid & i_ready at posedge; rd_ptr increments, wrapping.
- Stream output: o_valid = (count!=0); o_data = mem[rd_ptr] (show-ahead, zero-latency head). o_data must hold stable while o_valid=1 & i_ready=0.
- Latency: a byte pushed at edge N is visible on o_data/o_valid after edge N.
- Count update: push only → +1; pop only → −1; push & pop together → unchanged.
- Full handling: the full check uses the registered count, so a pop in the same cycle does not unblock a write; PREADY rises the cycle after the pop.
- o_level = count, registered. o_proto_err is cleared only by reset.

Test Plan:
- Single write: SETUP then ACCESS with PWDATA=8'hA5, i_ready=0 -> PREADY=1 in the first ACCESS cycle; o_valid=1, o_data=A5, o_level=1 next cycle.
- Fill and wait state:
  - Stimulus: four writes 11,22,33,44 with i_ready=0, then a fifth write 55.
  - Required: fifth write holds PREADY=0 for 3 cycles.
  - Then pulse i_ready for one cycle -> PREADY=1 the cycle after the pop; drain order 22,33,44,55; o_level returns to 0.
- Extended PENABLE: master holds PSEL=PENABLE=1 for 3 cycles after PREADY=1 -> exactly one entry pushed, o_level=1.
- Status read: read with FIFO empty -> PRDATA=1, PREADY=1; read with o_level=2 -> PRDATA=0; o_level unchanged by either read.
- Protocol error: PSEL=PENABLE=1 directly from IDLE with PWDATA=FF -> no push, o_proto_err=1 and stays 1 across later valid transfers.
- Reset mid-operation: o_level=3 with a write stalled in ACCESS, assert PRESET one cycle -> o_valid=0, o_level=0, PREADY=0, o_proto_err=0; a subsequent write of 5A appears as o_data=5A.

Source files
------------

// File: rtl/apb_tx_fifo_slave.sv
// APB completer that buffers written bytes in a show-ahead FIFO and
// streams them to a downstream protocol engine over valid/ready.
module apb_tx_fifo_slave #(
    parameter int unsigned m     = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          PCLK,
    input  logic          PRESET,
    input  logic          PSEL,
    input  logic          PENABLE,
    input  logic          PWRITE,
    input  logic [m-1:0]  PWDATA,
    output logic          PREADY,
    output logic          PRDATA,
    output logic [m-1:0]  o_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [AW:0]   o_level,
    output logic          o_proto_err
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        ACCESS   = 2'd2,
        COMPLETE = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [m-1:0]   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           full;
    logic           push;
    logic           pop;
    logic           err_set;

    // Full is judged on the registered count, so a same-cycle pop never unblocks a write.
    assign full = (count == (AW+1)'(DEPTH));
    assign pop  = o_valid & i_ready;

    // State register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic for the APB transfer sequence.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_nxt = SETUP;
                end else if (PSEL && PENABLE) begin
                    state_nxt = COMPLETE;
                end
            end
            SETUP: begin
                if (!PSEL) begin
                    state_nxt = IDLE;
                end else if (PENABLE) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_nxt = IDLE;
                end else if (PREADY) begin
                    state_nxt = COMPLETE;
                end
            end
            COMPLETE: begin
                if (!PSEL) begin
                    state_nxt = IDLE;
                end else if (!PENABLE) begin
                    state_nxt = SETUP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // APB responses, push strobe and protocol-error detection per state.
    always_comb begin
        PREADY  = 1'b0;
        PRDATA  = 1'b0;
        push    = 1'b0;
        err_set = 1'b0;
        case (state)
            IDLE: begin
                err_set = PSEL & PENABLE;
            end
            ACCESS: begin
                PREADY  = PWRITE ? ~full : 1'b1;
                PRDATA  = ~PWRITE & (count == '0);
                push    = PSEL & PENABLE & PWRITE & PREADY;
                err_set = ~PSEL;
            end
            default: ;
        endcase
    end

    // FIFO pointers, occupancy and sticky error flag.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            o_proto_err <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (err_set) begin
                o_proto_err <= 1'b1;
            end
        end
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge PCLK) begin
        if (push && !PRESET) begin
            mem[wr_ptr] <= PWDATA;
        end
    end

    assign o_data  = mem[rd_ptr];
    assign o_valid = (count != '0);
    assign o_level = count;

endmodule
